// File: rtl/chess_clock_pkg.sv
// Shared types and helpers for the N-player game clock: FSM state encoding
// and saturating arithmetic used on the per-player time counters.
package chess_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_FINISHED = 2'd3
  } state_e;

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                          input logic [31:0] b);
    return (b > a) ? 32'd0 : (a - b);
  endfunction

endpackage

// File: rtl/chess_clock_multi_if.sv
// Control/status bundle between the button front end (master) and the
// game clock (slave); times/active/fin/loser feed the display drivers.
interface chess_clock_multi_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int WIDTH       = 8
);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic                         enload;
  logic [WIDTH-1:0]             load_val;
  logic [WIDTH-1:0]             inc_val;
  logic                         inc_en;
  logic                         start;
  logic                         turn_done;
  logic                         pause;
  logic [NUM_PLAYERS*WIDTH-1:0] times;
  logic [PW-1:0]                active;
  logic                         running;
  logic                         fin;
  logic [PW-1:0]                loser;

  modport master (
    output enload, load_val, inc_val, inc_en, start, turn_done, pause,
    input  times, active, running, fin, loser
  );

  modport slave (
    input  enload, load_val, inc_val, inc_en, start, turn_done, pause,
    output times, active, running, fin, loser
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk by TICK_DIV while enabled; tick pulses on the last phase.
// Disabling holds the phase so a paused clock resumes mid-period.
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/chess_clock_multi.sv
// N-player game clock: one saturating down-counter per player, turn handover
// with optional Fischer increment, pause, and a finish flag naming the loser.
module chess_clock_multi
  import chess_clock_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int WIDTH       = 8,
  parameter int TICK_DIV    = 1
) (
  input logic                clk,
  input logic                reset,
  chess_clock_multi_if.slave bus
);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [PW-1:0]    LAST_PLAYER = PW'(NUM_PLAYERS - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] active_q, active_d;
  logic [PW-1:0] loser_q, loser_d;
  logic          running_q, running_d;
  logic          fin_q, fin_d;

  logic [WIDTH-1:0]             cnt_vec [NUM_PLAYERS];
  logic [NUM_PLAYERS*WIDTH-1:0] times_w;
  logic [WIDTH-1:0]             act_cnt;
  logic act_zero, run_live, start_go, load_all;
  logic tick, dec_to_zero, handover, pre_clr;

  assign act_cnt  = cnt_vec[active_q];
  assign act_zero = (act_cnt == '0);
  // An exhausted active counter takes precedence over pause and turn_done.
  assign run_live = (state_q == ST_RUN) && !act_zero && !bus.pause;
  assign start_go = (state_q == ST_IDLE) && bus.start && !bus.enload;
  assign load_all = bus.enload && ((state_q == ST_IDLE) || (state_q == ST_FINISHED));

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (run_live),
    .clr   (pre_clr),
    .tick  (tick)
  );

  // A tick that empties the counter wins over a same-cycle handover.
  assign dec_to_zero = tick && (act_cnt == WIDTH'(1));
  assign handover    = run_live && bus.turn_done && !dec_to_zero;
  assign pre_clr     = start_go || handover;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_cnt
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             is_act;

    assign is_act = (active_q == PW'(p));

    always_comb begin
      cnt_d = cnt_q;
      if (load_all) begin
        cnt_d = bus.load_val;
      end else if (is_act) begin
        if (tick)
          cnt_d = WIDTH'(sat_sub(32'(cnt_q), 32'd1));
        if (handover && bus.inc_en)
          cnt_d = WIDTH'(sat_add(32'(cnt_d), 32'(bus.inc_val), 32'(CNT_MAX)));
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign cnt_vec[p] = cnt_q;
  end

  always_comb begin
    times_w = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      times_w[p*WIDTH +: WIDTH] = cnt_vec[p];
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    loser_d  = loser_q;
    case (state_q)
      ST_IDLE: begin
        if (start_go) begin
          state_d  = ST_RUN;
          active_d = '0;
        end
      end
      ST_RUN: begin
        if (act_zero) begin
          state_d = ST_FINISHED;
          loser_d = active_q;
        end else if (bus.pause) begin
          state_d = ST_PAUSED;
        end else if (handover) begin
          active_d = (active_q == LAST_PLAYER) ? '0 : active_q + 1'b1;
        end
      end
      ST_PAUSED: begin
        if (!bus.pause) state_d = ST_RUN;
      end
      ST_FINISHED: begin
        if (bus.enload) begin
          state_d  = ST_IDLE;
          loser_d  = '0;
          active_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    running_d = (state_d == ST_RUN);
    fin_d     = (state_d == ST_FINISHED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      active_q  <= '0;
      loser_q   <= '0;
      running_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      loser_q   <= loser_d;
      running_q <= running_d;
      fin_q     <= fin_d;
    end
  end

  assign bus.times   = times_w;
  assign bus.active  = active_q;
  assign bus.running = running_q;
  assign bus.fin     = fin_q;
  assign bus.loser   = loser_q;

endmodule
